// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: alu_op classes, R-type funct codes,
// the decoded operation enum, the multiplier FSM state type and the decode helper.
// No logic of its own; latency and backpressure belong to the modules importing it.
package exec_pkg;

    // alu_op classes
    localparam logic [5:0] ALUOP_ADD   = 6'b000000;
    localparam logic [5:0] ALUOP_SUB   = 6'b000001;
    localparam logic [5:0] ALUOP_RTYPE = 6'b000010;

    // R-type funct codes (taken from sign_extend[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MUL,
        OP_ILL
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_e;

    // mul_en = 0 makes the mul funct fall through to the illegal op.
    function automatic op_e decode_op(input logic [5:0] alu_op,
                                      input logic [5:0] funct,
                                      input logic       mul_en);
        op_e op;
        op = OP_ILL;
        case (alu_op)
            ALUOP_ADD:   op = OP_ADD;
            ALUOP_SUB:   op = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_SLT:  op = OP_SLT;
                    FN_MUL:  op = mul_en ? OP_MUL : OP_ILL;
                    default: op = OP_ILL;
                endcase
            end
            default:     op = OP_ILL;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier returning the low DW bits of the unsigned product.
// Latency: DW cycles after start_i; done_o is high whenever no multiply is in flight.
// Backpressure: none internally; the product is held in acc until the next start_i.
//
// Ports: clk, reset (sync, active-high); start_i loads mcand_i/mplier_i and clears
// the accumulator; done_o flags count == 0; product_o is the accumulator.
module exec_mul_seq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [DW-1:0] mcand_i,
    input  logic [DW-1:0] mplier_i,
    output logic          done_o,
    output logic [DW-1:0] product_o
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
            acc_d    = '0;
            cnt_d    = CW'(DW);
        end else if (cnt_q != '0) begin
            // Bits shifted out of the multiplicand only affect the discarded high half.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign done_o    = (cnt_q == '0);
    assign product_o = acc_q;

endmodule

// File: rtl/execute_pipe.sv
// Registered execute stage: operand/destination mux, ALU, branch target, EX/MEM register.
// Latency: 1 cycle for single-cycle ops; DW+1 cycles for mul when EXEC_MUL_EN is defined.
// Backpressure: in_ready drops while the result is stalled or a multiply is in flight.
//
// Optional feature macro: EXEC_MUL_EN (adds the MUL state, exec_mul_seq and funct 011000).
// Ports: clk, reset (sync, active-high); in_valid/in_ready upstream handshake;
// alu_src, reg_dst, alu_op, pc_next, data1, data2, sign_extend, reg1, reg2 instruction
// fields; out_valid/out_ready downstream handshake; branch_pc, zero, alu_result,
// data2_out, dst registered results.
module execute_pipe
    import exec_pkg::*;
#(
    parameter int DW  = 32,
    parameter int PCW = 7,
    parameter int RW  = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           alu_src,
    input  logic           reg_dst,
    input  logic [5:0]     alu_op,
    input  logic [PCW-1:0] pc_next,
    input  logic [DW-1:0]  data1,
    input  logic [DW-1:0]  data2,
    input  logic [DW-1:0]  sign_extend,
    input  logic [RW-1:0]  reg1,
    input  logic [RW-1:0]  reg2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [PCW-1:0] branch_pc,
    output logic           zero,
    output logic [DW-1:0]  alu_result,
    output logic [DW-1:0]  data2_out,
    output logic [RW-1:0]  dst
);

`ifdef EXEC_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    // ---------------- decode and single-cycle datapath ----------------
    logic [DW-1:0]  opb;
    logic [RW-1:0]  dst_sel;
    logic [PCW-1:0] bpc_sel;
    logic [DW-1:0]  alu_res;
    op_e            op;

    assign opb     = alu_src ? sign_extend : data2;
    assign dst_sel = reg_dst ? reg2 : reg1;
    assign bpc_sel = pc_next + sign_extend[PCW-1:0];
    assign op      = decode_op(alu_op, sign_extend[5:0], MUL_EN);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = data1 + opb;
            OP_SUB:  alu_res = data1 - opb;
            OP_AND:  alu_res = data1 & opb;
            OP_OR:   alu_res = data1 | opb;
            OP_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(data1) < $signed(opb))};
            default: alu_res = '0;
        endcase
    end

    // ---------------- handshake ----------------
    logic out_free;
    logic accept;
    logic load_single;

    assign out_free    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign load_single = accept && (op != OP_MUL);

`ifdef EXEC_MUL_EN
    // ---------------- multiply FSM ----------------
    state_e         state_q, state_d;
    logic           mul_start;
    logic           mul_load;
    logic           mul_done;
    logic [DW-1:0]  mul_product;

    // Non-ALU fields of a mul are captured at accept and released with the product.
    logic [PCW-1:0] pend_bpc_q, pend_bpc_d;
    logic [DW-1:0]  pend_d2_q, pend_d2_d;
    logic [RW-1:0]  pend_dst_q, pend_dst_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && (op == OP_MUL)) state_d = ST_MUL;
            ST_MUL:  if (mul_done && out_free)     state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready depends on state and out_ready only, never on in_valid.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && out_free;
        mul_start = (state_q == ST_IDLE) && accept && (op == OP_MUL);
        mul_load  = (state_q == ST_MUL) && mul_done && out_free;
    end

    exec_mul_seq #(
        .DW(DW)
    ) u_mul (
        .clk      (clk),
        .reset    (reset),
        .start_i  (mul_start),
        .mcand_i  (data1),
        .mplier_i (opb),
        .done_o   (mul_done),
        .product_o(mul_product)
    );

    always_comb begin
        pend_bpc_d = pend_bpc_q;
        pend_d2_d  = pend_d2_q;
        pend_dst_d = pend_dst_q;
        if (mul_start) begin
            pend_bpc_d = bpc_sel;
            pend_d2_d  = data2;
            pend_dst_d = dst_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_bpc_q <= '0;
            pend_d2_q  <= '0;
            pend_dst_q <= '0;
        end else begin
            pend_bpc_q <= pend_bpc_d;
            pend_d2_q  <= pend_d2_d;
            pend_dst_q <= pend_dst_d;
        end
    end
`else
    assign in_ready = out_free;
`endif

    // ---------------- EX/MEM output register ----------------
    logic           out_valid_q, out_valid_d;
    logic [PCW-1:0] branch_pc_q, branch_pc_d;
    logic           zero_q, zero_d;
    logic [DW-1:0]  alu_result_q, alu_result_d;
    logic [DW-1:0]  data2_out_q, data2_out_d;
    logic [RW-1:0]  dst_q, dst_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        branch_pc_d  = branch_pc_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        data2_out_d  = data2_out_q;
        dst_d        = dst_q;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // A load in the same cycle as out_ready overrides the clear: full throughput.
        if (load_single) begin
            out_valid_d  = 1'b1;
            branch_pc_d  = bpc_sel;
            zero_d       = (alu_res == '0);
            alu_result_d = alu_res;
            data2_out_d  = data2;
            dst_d        = dst_sel;
        end
`ifdef EXEC_MUL_EN
        if (mul_load) begin
            out_valid_d  = 1'b1;
            branch_pc_d  = pend_bpc_q;
            zero_d       = (mul_product == '0);
            alu_result_d = mul_product;
            data2_out_d  = pend_d2_q;
            dst_d        = pend_dst_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            branch_pc_q  <= '0;
            zero_q       <= 1'b1;
            alu_result_q <= '0;
            data2_out_q  <= '0;
            dst_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            branch_pc_q  <= branch_pc_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            data2_out_q  <= data2_out_d;
            dst_q        <= dst_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign branch_pc  = branch_pc_q;
    assign zero       = zero_q;
    assign alu_result = alu_result_q;
    assign data2_out  = data2_out_q;
    assign dst        = dst_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Testbench for execute_pipe: directed scenarios plus randomized traffic against a
// queue-based reference model. Multiply checks follow the EXEC_MUL_EN setting.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_execute_pipe;

    localparam int DW  = 32;
    localparam int PCW = 7;
    localparam int RW  = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           alu_src = 1'b0;
    logic           reg_dst = 1'b0;
    logic [5:0]     alu_op = '0;
    logic [PCW-1:0] pc_next = '0;
    logic [DW-1:0]  data1 = '0;
    logic [DW-1:0]  data2 = '0;
    logic [DW-1:0]  sign_extend = '0;
    logic [RW-1:0]  reg1 = '0;
    logic [RW-1:0]  reg2 = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [PCW-1:0] branch_pc;
    logic           zero;
    logic [DW-1:0]  alu_result;
    logic [DW-1:0]  data2_out;
    logic [RW-1:0]  dst;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0]  res;
        logic           z;
        logic [PCW-1:0] bpc;
        logic [DW-1:0]  d2;
        logic [RW-1:0]  dst;
    } exp_t;

    exp_t exp_q[$];

    execute_pipe #(.DW(DW), .PCW(PCW), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_src    (alu_src),
        .reg_dst    (reg_dst),
        .alu_op     (alu_op),
        .pc_next    (pc_next),
        .data1      (data1),
        .data2      (data2),
        .sign_extend(sign_extend),
        .reg1       (reg1),
        .reg2       (reg2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .branch_pc  (branch_pc),
        .zero       (zero),
        .alu_result (alu_result),
        .data2_out  (data2_out),
        .dst        (dst)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU, straight from the operation table.
    function automatic logic [DW-1:0] model_alu(input logic [5:0] aop,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic [5:0] fn);
        logic [DW-1:0] prod;
        if (aop == 6'd0) return a + b;
        if (aop == 6'd1) return a - b;
        if (aop != 6'd2) return '0;
        case (fn)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
`ifdef EXEC_MUL_EN
            6'h18: begin
                prod = a * b;
                return prod;
            end
`endif
            default: return '0;
        endcase
    endfunction

    function automatic exp_t model_now();
        exp_t e;
        e.res = model_alu(alu_op, data1, alu_src ? sign_extend : data2, sign_extend[5:0]);
        e.z   = (e.res == '0);
        e.bpc = pc_next + sign_extend[PCW-1:0];
        e.d2  = data2;
        e.dst = reg_dst ? reg2 : reg1;
        return e;
    endfunction

    task automatic set_instr(input logic [5:0] aop, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] se,
                             input logic src, input logic rdst, input logic [RW-1:0] r1,
                             input logic [RW-1:0] r2, input logic [PCW-1:0] pc);
        alu_op = aop; data1 = a; data2 = b; sign_extend = se; alu_src = src;
        reg_dst = rdst; reg1 = r1; reg2 = r2; pc_next = pc;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (alu_result !== '0) begin errors++; $display("FAIL reset_alu_result got=%h exp=0", alu_result); end
        checks++; if (data2_out !== '0) begin errors++; $display("FAIL reset_data2_out got=%h exp=0", data2_out); end
        checks++; if (dst !== '0) begin errors++; $display("FAIL reset_dst got=%h exp=0", dst); end
        checks++; if (branch_pc !== '0) begin errors++; $display("FAIL reset_branch_pc got=%h exp=0", branch_pc); end
    endtask

    task automatic test_rtype_add();
        set_instr(6'd2, 5, 7, 32'h20, 1'b0, 1'b1, 5'd3, 5'd9, 7'd10);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
        checks++; if (alu_result !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", alu_result); end
        checks++; if (dst !== 5'd9) begin errors++; $display("FAIL add_dst got=%0d exp=9", dst); end
        checks++; if (branch_pc !== 7'd42) begin errors++; $display("FAIL add_branch_pc got=%0d exp=42", branch_pc); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got=%b exp=0", zero); end
        checks++; if (data2_out !== 32'd7) begin errors++; $display("FAIL add_data2_out got=%0d exp=7", data2_out); end
    endtask

    task automatic test_branch_wrap();
        // Previous result is consumed in the same cycle the branch is accepted.
        out_ready = 1'b1;
        set_instr(6'd1, 3, 3, 32'd4, 1'b0, 1'b0, 5'd1, 5'd2, 7'h7E);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (alu_result !== '0) begin errors++; $display("FAIL sub_result got=%h exp=0", alu_result); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got=%b exp=1", zero); end
        checks++; if (branch_pc !== 7'h02) begin errors++; $display("FAIL sub_branch_pc got=%h exp=02", branch_pc); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid got=%b exp=1", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        set_instr(6'd0, 1, 2, 32'd0, 1'b0, 1'b0, 5'd4, 5'd5, 7'd20);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            checks++;
            if (alu_result !== '0 || zero !== 1'b1 || branch_pc !== 7'h02 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_frozen cyc=%0d got res=%h z=%b bpc=%h v=%b exp res=0 z=1 bpc=02 v=1",
                         i, alu_result, zero, branch_pc, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_result !== 32'd3 || dst !== 5'd4 || branch_pc !== 7'd20) begin
            errors++;
            $display("FAIL stall_new_result got v=%b res=%0d dst=%0d bpc=%0d exp v=1 res=3 dst=4 bpc=20",
                     out_valid, alu_result, dst, branch_pc);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        int n;
        do_reset();
        out_ready = 1'b1;
        set_instr(6'd2, 32'hFFFF_FFFF, 32'd3, 32'h18, 1'b0, 1'b1, 5'd0, 5'd7, 7'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (in_ready === 1'b0 && n < 100) begin
            n++;
            if (in_ready === 1'b0 && out_valid !== 1'b0) begin
                // a result may not appear while still busy
                checks++; errors++;
                $display("FAIL mul_early_valid cyc=%0d", n);
            end
            step();
        end
        checks++; if (n != DW + 1) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", n, DW + 1); end
        checks++; if (out_valid !== 1'b1 || alu_result !== 32'hFFFF_FFFD || dst !== 5'd7) begin
            errors++;
            $display("FAIL mul_result got v=%b res=%h dst=%0d exp v=1 res=fffffffd dst=7", out_valid, alu_result, dst);
        end
        step();
        // Reset partway through a multiply discards it.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_abort got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid !== 1'b0) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL mul_abort_quiet got=%0d valid cycles exp=0", n); end
    endtask
`else
    task automatic test_mul();
        do_reset();
        out_ready = 1'b1;
        set_instr(6'd2, 32'hFFFF_FFFF, 32'd3, 32'h18, 1'b0, 1'b1, 5'd0, 5'd7, 7'd0);
        in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nomul_in_ready got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_result !== '0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL nomul_result got v=%b res=%h z=%b exp v=1 res=0 z=1", out_valid, alu_result, zero);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nomul_in_ready_after got=%b exp=1", in_ready); end
    endtask
`endif

    task automatic drive_rand();
        logic [5:0] fn_tab [8];
        int r;
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h00, 6'h3F};
        r = $urandom_range(0, 9);
        if (r < 3)      alu_op = 6'd0;
        else if (r < 5) alu_op = 6'd1;
        else if (r < 9) alu_op = 6'd2;
        else            alu_op = 6'($urandom_range(3, 63));
        data1 = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        data2 = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
        sign_extend = DW'($urandom);
        sign_extend[5:0] = fn_tab[$urandom_range(0, 7)];
        alu_src = 1'($urandom);
        reg_dst = 1'($urandom);
        reg1 = RW'($urandom);
        reg2 = RW'($urandom);
        pc_next = PCW'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // One cycle of scoreboard bookkeeping, evaluated just before the edge.
    task automatic score_cycle();
        exp_t e;
        checks++;
        if (in_ready === 1'b1 && !(out_valid === 1'b0 || out_ready === 1'b1)) begin
            errors++;
            $display("FAIL rand_in_ready_rule rdy=%b v=%b ordy=%b", in_ready, out_valid, out_ready);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rand_unexpected_output res=%h", alu_result);
            end else begin
                e = exp_q.pop_front();
                if (alu_result !== e.res || zero !== e.z || branch_pc !== e.bpc ||
                    data2_out !== e.d2 || dst !== e.dst) begin
                    errors++;
                    $display("FAIL rand_output got res=%h z=%b bpc=%h d2=%h dst=%h exp res=%h z=%b bpc=%h d2=%h dst=%h",
                             alu_result, zero, branch_pc, data2_out, dst, e.res, e.z, e.bpc, e.d2, e.dst);
                end
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(model_now());
    endtask

    task automatic test_random();
        int n;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            #1;
            score_cycle();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
            #1;
            score_cycle();
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        // Full throughput: one accept per cycle with out_ready held high.
        logic [DW-1:0] expv [4];
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_instr(6'd0, DW'(i * 10), DW'(i + 1), 32'd0, 1'b0, 1'b0, RW'(i), 5'd0, 7'd0);
            expv[i] = DW'(i * 10 + i + 1);
            in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || alu_result !== expv[i]) begin
                errors++;
                $display("FAIL b2b_result i=%0d got v=%b res=%0d exp v=1 res=%0d", i, out_valid, alu_result, expv[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_branch_wrap();
        test_stall();
        test_back_to_back();
        test_mul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
